// File: rtl/instr_loader.sv
// Instruction loader: receives a framed byte stream, assembles 15-bit
// instruction words, writes them into the instruction memory and verifies
// the trailing XOR checksum before flagging the image as ready to fetch.
//
// Frame: count byte N, then N {lo, hi} byte pairs (hi bit 7 must be 0),
// then one checksum byte = XOR of the count byte and all data bytes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for load_start after reset
// HDR   | waiting for the word-count byte
// LO    | waiting for the low byte of the next word
// HI    | waiting for the high byte; a legal one triggers the memory write
// CHK   | waiting for the checksum byte
// DONE  | frame written and checksum matched; holds until load_start
// ERR   | frame rejected (bad count, bad hi byte or bad checksum)

module instr_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 1,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic              WE,
  output logic [14:0]       WrData,
  output logic [ADDR_W-1:0] Addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word counter must hold MAX_WORDS itself, since the count byte is latched.
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  // The whole frame has to fit between BASE_ADDR and the top of memory, and
  // the word count has to be expressible in the single count byte.
  if (BASE_ADDR + MAX_WORDS > (1 << ADDR_W)) begin : gAddrRangeCheck
    $error("instr_loader: BASE_ADDR + MAX_WORDS exceeds the address space");
  end
  if (MAX_WORDS > 255 || MAX_WORDS < 1) begin : gCountRangeCheck
    $error("instr_loader: MAX_WORDS must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loaderState_t;

  loaderState_t state;
  loaderState_t stateNext;

  logic [CNT_W-1:0]  nWords;
  logic [CNT_W-1:0]  wordCnt;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        loByte;
  logic [7:0]        xorAcc;

  logic accept;
  logic hdrBad;
  logic hiBad;
  logic lastWord;
  logic startFrame;
  logic inFrame;

  // Handshake and frame-validity decodes, all derived from the current state
  // and the byte on the bus.
  assign inFrame    = (state == HDR) || (state == LO) || (state == HI) || (state == CHK);
  assign byte_ready = inFrame;
  assign accept     = byte_valid && byte_ready;
  assign hdrBad     = (byte_in == 8'd0) || (int'(byte_in) > MAX_WORDS);
  assign hiBad      = byte_in[7];
  assign lastWord   = ((wordCnt + CNT_W'(1)) == nWords);
  // A new frame can only be opened from the resting states; load_start is
  // deliberately ignored while a frame is in flight.
  assign startFrame = load_start &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));

  // Status flags follow the state directly so they drop on the same edge
  // that leaves DONE/ERR.
  assign busy = inFrame;
  assign done = (state == DONE);
  assign err  = (state == ERR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode; every in-frame state holds while no byte is accepted.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (startFrame) begin
          stateNext = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          stateNext = hdrBad ? ERR : LO;
        end
      end
      LO: begin
        if (accept) begin
          stateNext = HI;
        end
      end
      HI: begin
        if (accept) begin
          if (hiBad) begin
            stateNext = ERR;
          end else if (lastWord) begin
            stateNext = CHK;
          end else begin
            stateNext = LO;
          end
        end
      end
      CHK: begin
        if (accept) begin
          stateNext = (byte_in == xorAcc) ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (startFrame) begin
          stateNext = HDR;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Running XOR over the count and data bytes; the checksum byte itself is
  // only compared, never folded in.
  always_ff @(posedge clk) begin
    if (reset) begin
      xorAcc <= 8'd0;
    end else if (startFrame) begin
      xorAcc <= 8'd0;
    end else if (accept && (state != CHK)) begin
      xorAcc <= xorAcc ^ byte_in;
    end
  end

  // Frame bookkeeping: word count, progress counter, address pointer and the
  // low byte waiting for its high half.
  always_ff @(posedge clk) begin
    if (reset) begin
      nWords  <= '0;
      wordCnt <= '0;
      ptr     <= '0;
      loByte  <= 8'd0;
    end else if (accept) begin
      case (state)
        HDR: begin
          if (!hdrBad) begin
            nWords  <= byte_in[CNT_W-1:0];
            wordCnt <= '0;
            ptr     <= ADDR_W'(BASE_ADDR);
          end
        end
        LO: begin
          loByte <= byte_in;
        end
        HI: begin
          if (!hiBad) begin
            wordCnt <= wordCnt + CNT_W'(1);
            ptr     <= ptr + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory write port: a one-cycle WE pulse with registered address and
  // data. Reset has priority, so a write being accepted on a reset edge is
  // dropped. Address and data hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      WE     <= 1'b0;
      WrData <= 15'd0;
      Addr   <= '0;
    end else begin
      WE <= 1'b0;
      if (accept && (state == HI) && !hiBad) begin
        WE     <= 1'b1;
        WrData <= {byte_in[6:0], loByte};
        Addr   <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader with a behavioural instruction memory
// and a write-port monitor.
module tb_instr_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_in = 8'd0;
  logic              byte_ready;
  logic              WE;
  logic [14:0]       WrData;
  logic [ADDR_W-1:0] Addr;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(1), .MAX_WORDS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .WE         (WE),
    .WrData     (WrData),
    .Addr       (Addr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory; memClr wipes it between scenarios.
  logic [14:0] mem [0:63];
  logic        memClr = 1'b0;
  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 15'd0;
    end else if (WE) begin
      mem[Addr] <= WrData;
    end
  end

  // Write-port monitor: logs every write and flags adjacent WE cycles and
  // WE pulses not preceded by an accepted byte.
  logic [ADDR_W-1:0] logAddr [0:127];
  logic [14:0]       logData [0:127];
  int  weCount = 0;
  int  backToBack = 0;
  int  orphanWe = 0;
  logic weLast = 1'b0;
  logic acceptPrev = 1'b0;

  always @(posedge clk) acceptPrev <= byte_valid && byte_ready;

  always @(negedge clk) begin
    if (WE) begin
      if (weCount < 128) begin
        logAddr[weCount] = Addr;
        logData[weCount] = WrData;
      end
      weCount = weCount + 1;
      if (weLast) backToBack = backToBack + 1;
      if (!acceptPrev) orphanWe = orphanWe + 1;
    end
    weLast = WE;
  end

  task automatic clearMem();
    memClr = 1'b1;
    @(negedge clk);
    memClr = 1'b0;
  endtask

  task automatic startLoad();
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout byte=%h byte_ready=%b required=1", b, byte_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({WE, WrData, Addr, busy, done, err, byte_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0",
               {WE, WrData, Addr, busy, done, err, byte_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, byte_ready, WE} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b required=00000", {busy, done, err, byte_ready, WE});
    end
    clearMem();
  endtask

  task automatic test_basic_frame();
    int base;
    base = weCount;
    startLoad();
    checks++;
    if ({busy, byte_ready, done, err} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_hdr_state got=%b required=1100", {busy, byte_ready, done, err});
    end
    sendByte(8'h02, 0);
    sendByte(8'h34, 0);
    sendByte(8'h12, 0);
    sendByte(8'hBC, 0);
    sendByte(8'h0A, 0);
    sendByte(8'h92, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (weCount - base !== 2) begin
      errors++;
      $display("FAIL basic_write_count got=%0d required=2", weCount - base);
    end else begin
      checks++;
      if (logAddr[base] !== 6'd1 || logData[base] !== 15'h1234) begin
        errors++;
        $display("FAIL basic_write0 got=%0d/%h required=1/1234", logAddr[base], logData[base]);
      end
      checks++;
      if (logAddr[base+1] !== 6'd2 || logData[base+1] !== 15'h0ABC) begin
        errors++;
        $display("FAIL basic_write1 got=%0d/%h required=2/0abc", logAddr[base+1], logData[base+1]);
      end
    end
    checks++;
    if ({done, err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL basic_status got=%b required=100", {done, err, busy});
    end
    checks++;
    if (mem[1] !== 15'h1234 || mem[2] !== 15'h0ABC) begin
      errors++;
      $display("FAIL basic_mem got=%h,%h required=1234,0abc", mem[1], mem[2]);
    end
    // done must stay put while nothing happens
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky got=%b required=1", done);
    end
  endtask

  task automatic test_gaps();
    int base;
    int b2b0;
    int orph0;
    logic [7:0] frame [0:5];
    frame[0] = 8'h02; frame[1] = 8'h34; frame[2] = 8'h12;
    frame[3] = 8'hBC; frame[4] = 8'h0A; frame[5] = 8'h92;
    clearMem();
    base  = weCount;
    b2b0  = backToBack;
    orph0 = orphanWe;
    startLoad();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done_cleared got=%b required=0", done);
    end
    for (int i = 0; i < 6; i++) sendByte(frame[i], int'($urandom_range(0, 5)));
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (weCount - base !== 2) begin
      errors++;
      $display("FAIL gaps_write_count got=%0d required=2", weCount - base);
    end else begin
      checks++;
      if (logAddr[base] !== 6'd1 || logData[base] !== 15'h1234 ||
          logAddr[base+1] !== 6'd2 || logData[base+1] !== 15'h0ABC) begin
        errors++;
        $display("FAIL gaps_writes got=%0d/%h %0d/%h required=1/1234 2/0abc",
                 logAddr[base], logData[base], logAddr[base+1], logData[base+1]);
      end
    end
    checks++;
    if (backToBack !== b2b0 || orphanWe !== orph0) begin
      errors++;
      $display("FAIL gaps_we_spacing got=b2b %0d orphan %0d required=0 0",
               backToBack - b2b0, orphanWe - orph0);
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL gaps_status got=%b required=10", {done, err});
    end
  endtask

  task automatic test_bad_header();
    int base;
    logic [7:0] hdr [0:1];
    hdr[0] = 8'h00;
    hdr[1] = 8'h11;
    base = weCount;
    for (int k = 0; k < 2; k++) begin
      startLoad();
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL badhdr_clear got=%b required=00", {done, err});
      end
      sendByte(hdr[k], 0);
      checks++;
      if ({err, done, busy, byte_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL badhdr_err hdr=%h got=%b required=1000", hdr[k], {err, done, busy, byte_ready});
      end
      byte_in = 8'h01;
      repeat (3) @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL badhdr_hold hdr=%h got=%b required=01", hdr[k], {byte_ready, err});
      end
      byte_valid = 1'b0;
    end
    checks++;
    if (weCount !== base) begin
      errors++;
      $display("FAIL badhdr_no_write got=%0d required=0", weCount - base);
    end
  endtask

  task automatic test_hi_bit7();
    int base;
    base = weCount;
    startLoad();
    sendByte(8'h01, 0);
    sendByte(8'h55, 0);
    sendByte(8'h80, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({err, done, busy} !== 3'b100) begin
      errors++;
      $display("FAIL hibit_status got=%b required=100", {err, done, busy});
    end
    checks++;
    if (weCount !== base) begin
      errors++;
      $display("FAIL hibit_no_write got=%0d required=0", weCount - base);
    end
    checks++;
    if (mem[1] !== 15'h1234 || mem[2] !== 15'h0ABC) begin
      errors++;
      $display("FAIL hibit_mem got=%h,%h required=1234,0abc", mem[1], mem[2]);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    clearMem();
    base = weCount;
    startLoad();
    sendByte(8'h01, 0);
    sendByte(8'h34, 0);
    sendByte(8'h12, 0);
    sendByte(8'h00, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (weCount - base !== 1) begin
      errors++;
      $display("FAIL badchk_write_count got=%0d required=1", weCount - base);
    end else begin
      checks++;
      if (logAddr[base] !== 6'd1 || logData[base] !== 15'h1234) begin
        errors++;
        $display("FAIL badchk_write got=%0d/%h required=1/1234", logAddr[base], logData[base]);
      end
    end
    checks++;
    if ({err, done} !== 2'b10) begin
      errors++;
      $display("FAIL badchk_status got=%b required=10", {err, done});
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    clearMem();
    base = weCount;
    startLoad();
    sendByte(8'h10, 0);
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++;
    if ({busy, byte_ready, err, done} !== 4'b1100) begin
      errors++;
      $display("FAIL busy_ignore_start got=%b required=1100", {busy, byte_ready, err, done});
    end
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    sendByte(8'h33, 0);
    // hi byte of word 2 presented on the same edge as reset
    byte_in    = 8'h44;
    byte_valid = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({WE, busy, done, err, byte_ready} !== 5'b0 || Addr !== 6'd0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b addr=%0d required=00000 addr=0",
               {WE, busy, done, err, byte_ready}, Addr);
    end
    checks++;
    if (weCount - base !== 1) begin
      errors++;
      $display("FAIL midreset_write_count got=%0d required=1", weCount - base);
    end
    checks++;
    if (mem[1] !== 15'h2211 || mem[2] !== 15'h0000) begin
      errors++;
      $display("FAIL midreset_mem got=%h,%h required=2211,0000", mem[1], mem[2]);
    end
    base = weCount;
    startLoad();
    sendByte(8'h01, 0);
    sendByte(8'hAB, 0);
    sendByte(8'h05, 0);
    sendByte(8'hAF, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (weCount - base !== 1 || mem[1] !== 15'h05AB) begin
      errors++;
      $display("FAIL reload_write got=%0d/%h required=1/05ab", weCount - base, mem[1]);
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL reload_status got=%b required=10", {done, err});
    end
  endtask

  task automatic test_max_words();
    int base;
    clearMem();
    base = weCount;
    startLoad();
    sendByte(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      sendByte(8'(i), 0);
      sendByte(8'(8'h40 | i), 0);
    end
    sendByte(8'h10, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (weCount - base !== 16) begin
      errors++;
      $display("FAIL max_write_count got=%0d required=16", weCount - base);
    end else begin
      checks++;
      if (logAddr[base] !== 6'd1 || logData[base] !== 15'h4000) begin
        errors++;
        $display("FAIL max_first got=%0d/%h required=1/4000", logAddr[base], logData[base]);
      end
      checks++;
      if (logAddr[base+15] !== 6'd16 || logData[base+15] !== 15'h4F0F) begin
        errors++;
        $display("FAIL max_last got=%0d/%h required=16/4f0f", logAddr[base+15], logData[base+15]);
      end
    end
    checks++;
    if (mem[16] !== 15'h4F0F || mem[17] !== 15'h0000) begin
      errors++;
      $display("FAIL max_mem got=%h,%h required=4f0f,0000", mem[16], mem[17]);
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL max_status got=%b required=10", {done, err});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_gaps();
    test_bad_header();
    test_hi_bit7();
    test_bad_checksum();
    test_reset_midframe();
    test_max_words();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1);
  end

endmodule
